// File: rtl/seq_pkg.sv
// Shared encodings for the PC call sequencer: decoded ops, FSM states and error codes.
package seq_pkg;

    typedef enum logic [2:0] {
        OP_SEQ  = 3'd0,
        OP_JMP  = 3'd1,
        OP_BR   = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4,
        OP_HALT = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_RET_WAIT = 2'd1,
        S_HALT     = 2'd2,
        S_ERROR    = 2'd3
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_UNF  = 2'b10;
    localparam logic [1:0] ERR_ILL  = 2'b11;

endpackage

// File: rtl/pc_call_sequencer.sv
// Next-PC generator and control FSM for instruction fetch; drives the return-address stack
// and tracks call depth locally so stack overflow/underflow never reach the stack itself.
module pc_call_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned         ADDR_W        = 16,
    parameter int unsigned         STACK_ENTRIES = 4,
    parameter logic [ADDR_W-1:0]   RESET_PC      = '0,
    localparam int unsigned        DEPTH_W       = $clog2(STACK_ENTRIES + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [2:0]          op,
    input  logic [ADDR_W-1:0]   target,
    input  logic                cond,
    input  logic                restart,
    input  logic [ADDR_W-1:0]   stk_q,
    output logic [ADDR_W-1:0]   pc,
    output logic                pc_valid,
    output logic                stk_push,
    output logic                stk_pop,
    output logic [ADDR_W-1:0]   stk_d,
    output logic                stk_clr,
    output logic [DEPTH_W-1:0]  depth,
    output logic                halted,
    output logic                err,
    output logic [1:0]          err_code
);

    state_e               state_q;
    logic [ADDR_W-1:0]    pc_q;
    logic [DEPTH_W-1:0]   depth_q;
    logic [1:0]           err_code_q;

    logic [ADDR_W-1:0]    pc_inc;
    logic                 run_acc;
    logic                 call_ok;
    logic                 ret_ok;
    logic                 stopped;

    assign pc_inc  = pc_q + ADDR_W'(1);
    assign run_acc = (state_q == S_RUN) && en;
    assign call_ok = (depth_q < DEPTH_W'(STACK_ENTRIES));
    assign ret_ok  = (depth_q != '0);
    assign stopped = (state_q == S_HALT) || (state_q == S_ERROR);

    // Stack handshake is combinational so the push/pop lands on the same edge as the PC update.
    assign stk_push = run_acc && (op == OP_CALL) && call_ok;
    assign stk_pop  = run_acc && (op == OP_RET) && ret_ok;
    assign stk_d    = pc_inc;
    assign stk_clr  = stopped && restart;

    assign pc       = pc_q;
    assign pc_valid = (state_q == S_RUN);
    assign halted   = (state_q == S_HALT);
    assign err      = (state_q == S_ERROR);
    assign depth    = depth_q;
    assign err_code = err_code_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_RUN;
            pc_q       <= RESET_PC;
            depth_q    <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (en) begin
                        case (op_e'(op))
                            OP_SEQ:  pc_q <= pc_inc;
                            OP_JMP:  pc_q <= target;
                            OP_BR:   pc_q <= cond ? target : pc_inc;
                            OP_CALL: begin
                                if (call_ok) begin
                                    pc_q    <= target;
                                    depth_q <= depth_q + DEPTH_W'(1);
                                end else begin
                                    state_q    <= S_ERROR;
                                    err_code_q <= ERR_OVF;
                                end
                            end
                            OP_RET: begin
                                if (ret_ok) begin
                                    depth_q <= depth_q - DEPTH_W'(1);
                                    state_q <= S_RET_WAIT;
                                end else begin
                                    state_q    <= S_ERROR;
                                    err_code_q <= ERR_UNF;
                                end
                            end
                            OP_HALT: state_q <= S_HALT;
                            default: begin
                                state_q    <= S_ERROR;
                                err_code_q <= ERR_ILL;
                            end
                        endcase
                    end
                end
                // Stack read data is registered, so the return address only arrives here.
                S_RET_WAIT: begin
                    pc_q    <= stk_q;
                    state_q <= S_RUN;
                end
                S_HALT, S_ERROR: begin
                    if (restart) begin
                        pc_q       <= RESET_PC;
                        depth_q    <= '0;
                        err_code_q <= ERR_NONE;
                        state_q    <= S_RUN;
                    end
                end
                default: state_q <= S_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_call_sequencer.sv
// Directed bench for pc_call_sequencer with hand-computed expected values.
module tb_pc_call_sequencer;
    import seq_pkg::*;

    logic        clk;
    logic        reset;
    logic        en;
    logic [2:0]  op;
    logic [15:0] target;
    logic        cond;
    logic        restart;
    logic [15:0] stk_q;
    logic [15:0] pc;
    logic        pc_valid;
    logic        stk_push;
    logic        stk_pop;
    logic [15:0] stk_d;
    logic        stk_clr;
    logic [2:0]  depth;
    logic        halted;
    logic        err;
    logic [1:0]  err_code;

    int n_checks = 0;
    int n_errors = 0;

    pc_call_sequencer #(
        .ADDR_W(16),
        .STACK_ENTRIES(4),
        .RESET_PC(16'h0000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .op(op),
        .target(target),
        .cond(cond),
        .restart(restart),
        .stk_q(stk_q),
        .pc(pc),
        .pc_valid(pc_valid),
        .stk_push(stk_push),
        .stk_pop(stk_pop),
        .stk_d(stk_d),
        .stk_clr(stk_clr),
        .depth(depth),
        .halted(halted),
        .err(err),
        .err_code(err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [2:0] o, input logic [15:0] t, input logic c);
        en     = e;
        op     = o;
        target = t;
        cond   = c;
        #1;
    endtask

    task automatic do_restart();
        drive(1'b0, OP_SEQ, 16'h0, 1'b0);
        restart = 1'b1;
        #1;
        check("restart_clr", {31'b0, stk_clr}, 32'd1);
        tick();
        restart = 1'b0;
        #1;
        check("restart_clr_drop", {31'b0, stk_clr}, 32'd0);
        check("restart_pc", {16'b0, pc}, 32'h0);
        check("restart_depth", {29'b0, depth}, 32'd0);
        check("restart_err", {31'b0, err}, 32'd0);
        check("restart_valid", {31'b0, pc_valid}, 32'd1);
        check("restart_code", {30'b0, err_code}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        en      = 1'b0;
        op      = OP_SEQ;
        target  = 16'h0;
        cond    = 1'b0;
        restart = 1'b0;
        stk_q   = 16'h0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_pc", {16'b0, pc}, 32'h0);
        check("rst_valid", {31'b0, pc_valid}, 32'd1);
        check("rst_depth", {29'b0, depth}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_code", {30'b0, err_code}, 32'd0);
        check("rst_halted", {31'b0, halted}, 32'd0);
        check("rst_clr", {31'b0, stk_clr}, 32'd0);

        // Sequential fetch
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, OP_SEQ, 16'h0, 1'b0);
            check("seq_push", {31'b0, stk_push}, 32'd0);
            check("seq_pop", {31'b0, stk_pop}, 32'd0);
            tick();
            check("seq_pc", {16'b0, pc}, i);
        end

        // Call and return
        drive(1'b1, OP_JMP, 16'h0010, 1'b0);
        tick();
        check("jmp_pc", {16'b0, pc}, 32'h0010);
        drive(1'b1, OP_CALL, 16'h0100, 1'b0);
        check("call_push", {31'b0, stk_push}, 32'd1);
        check("call_pop", {31'b0, stk_pop}, 32'd0);
        check("call_d", {16'b0, stk_d}, 32'h0011);
        tick();
        check("call_pc", {16'b0, pc}, 32'h0100);
        check("call_depth", {29'b0, depth}, 32'd1);
        drive(1'b1, OP_JMP, 16'h0105, 1'b0);
        tick();
        drive(1'b1, OP_RET, 16'h0, 1'b0);
        check("ret_pop", {31'b0, stk_pop}, 32'd1);
        check("ret_push", {31'b0, stk_push}, 32'd0);
        tick();
        check("retw_valid", {31'b0, pc_valid}, 32'd0);
        check("retw_pc", {16'b0, pc}, 32'h0105);
        check("retw_depth", {29'b0, depth}, 32'd0);
        stk_q = 16'h0011;
        drive(1'b1, OP_CALL, 16'h0999, 1'b0);
        check("retw_push_ignored", {31'b0, stk_push}, 32'd0);
        tick();
        check("ret_pc", {16'b0, pc}, 32'h0011);
        check("ret_valid", {31'b0, pc_valid}, 32'd1);
        check("ret_depth", {29'b0, depth}, 32'd0);

        // Overflow on the fifth nested call
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, OP_CALL, 16'h0200 + 16'(i), 1'b0);
            check("nest_push", {31'b0, stk_push}, 32'd1);
            tick();
            check("nest_depth", {29'b0, depth}, i + 1);
        end
        drive(1'b1, OP_CALL, 16'h0300, 1'b0);
        check("ovf_push", {31'b0, stk_push}, 32'd0);
        tick();
        check("ovf_err", {31'b0, err}, 32'd1);
        check("ovf_code", {30'b0, err_code}, 32'd1);
        check("ovf_pc", {16'b0, pc}, 32'h0203);
        check("ovf_valid", {31'b0, pc_valid}, 32'd0);
        check("ovf_depth", {29'b0, depth}, 32'd4);
        do_restart();

        // Underflow and illegal op
        drive(1'b1, OP_RET, 16'h0, 1'b0);
        check("unf_pop", {31'b0, stk_pop}, 32'd0);
        tick();
        check("unf_err", {31'b0, err}, 32'd1);
        check("unf_code", {30'b0, err_code}, 32'd2);
        do_restart();
        drive(1'b1, 3'd7, 16'h0, 1'b0);
        tick();
        check("ill_code", {30'b0, err_code}, 32'd3);
        check("ill_err", {31'b0, err}, 32'd1);
        do_restart();

        // Branches, wrap, hold
        drive(1'b1, OP_JMP, 16'h0020, 1'b0);
        tick();
        drive(1'b1, OP_BR, 16'h0080, 1'b0);
        tick();
        check("br_nt", {16'b0, pc}, 32'h0021);
        drive(1'b1, OP_BR, 16'h0040, 1'b1);
        tick();
        check("br_t", {16'b0, pc}, 32'h0040);
        drive(1'b1, OP_JMP, 16'hFFFF, 1'b0);
        tick();
        drive(1'b1, OP_SEQ, 16'h0, 1'b0);
        check("wrap_d", {16'b0, stk_d}, 32'h0000);
        tick();
        check("wrap_pc", {16'b0, pc}, 32'h0000);
        drive(1'b1, OP_SEQ, 16'h0, 1'b0);
        tick();
        drive(1'b0, OP_JMP, 16'h0555, 1'b0);
        tick();
        tick();
        check("hold_pc", {16'b0, pc}, 32'h0001);

        // Halt
        drive(1'b1, OP_HALT, 16'h0, 1'b0);
        tick();
        check("halt_halted", {31'b0, halted}, 32'd1);
        check("halt_valid", {31'b0, pc_valid}, 32'd0);
        drive(1'b1, OP_JMP, 16'h0077, 1'b0);
        tick();
        check("halt_pc", {16'b0, pc}, 32'h0001);
        check("halt_still", {31'b0, halted}, 32'd1);
        do_restart();

        // Asynchronous reset during RET_WAIT
        drive(1'b1, OP_CALL, 16'h0300, 1'b0);
        tick();
        drive(1'b1, OP_CALL, 16'h0400, 1'b0);
        tick();
        drive(1'b1, OP_RET, 16'h0, 1'b0);
        tick();
        check("arst_pre_valid", {31'b0, pc_valid}, 32'd0);
        check("arst_pre_depth", {29'b0, depth}, 32'd1);
        en    = 1'b0;
        stk_q = 16'h0BAD;
        #2;
        reset = 1'b1;
        #1;
        check("arst_pc", {16'b0, pc}, 32'h0000);
        check("arst_valid", {31'b0, pc_valid}, 32'd1);
        check("arst_depth", {29'b0, depth}, 32'd0);
        #1;
        reset = 1'b0;
        tick();
        check("arst_after_pc", {16'b0, pc}, 32'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_call_sequencer.md
Name: pc_call_sequencer

Overview:
- Program-counter sequencer for the PIM controller's instruction fetch path; sits directly upstream of the return-address stack.
- Takes decoded control ops (sequential, jump, branch, call, return, halt) and generates the next PC.
- Drives the stack's push/pop/data inputs and consumes its registered read data on return.
- Tracks call depth itself, so overflow/underflow are caught before the stack is corrupted.

Parameters:
- ADDR_W, 16, PC / return-address width; equals the stack data width.
- STACK_ENTRIES, 4, maximum nested calls the attached stack holds.
- RESET_PC, 0, PC value after reset or restart.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  instruction at pc is valid and accepted this cycle.
- op  in  3  decoded op: 0 SEQ, 1 JMP, 2 BR, 3 CALL, 4 RET, 5 HALT, 6/7 illegal.
- target  in  ADDR_W  jump/branch/call destination.
- cond  in  1  branch condition, used only for BR.
- restart  in  1  leave HALT/ERROR and restart at RESET_PC.
- stk_q  in  ADDR_W  stack read data, valid the cycle after stk_pop.
- pc  out  ADDR_W  current program counter.
- pc_valid  out  1  pc is a fetchable address (state RUN).
- stk_push  out  1  push request to stack.
- stk_pop  out  1  pop request to stack.
- stk_d  out  ADDR_W  return address to push (pc+1).
- stk_clr  out  1  one-cycle pulse, ORed into the stack reset on restart.
- depth  out  $clog2(STACK_ENTRIES+1)  current call depth.
- halted  out  1  state HALT.
- err  out  1  state ERROR.
- err_code  out  2  01 overflow, 10 underflow, 11 illegal op; 00 otherwise.

Behaviour:
- **Reset** (async, immediate): pc=RESET_PC, state RUN, depth=0, err=0, err_code=00, halted=0, stk_clr=0.
- **States:** RUN, RET_WAIT, HALT, ERROR.
- **Output timing:**
  - pc_valid = (state==RUN); halted and err are decoded from state.
  - stk_push, stk_pop and stk_d are combinational from state, en, op, pc and depth; no added latency.
  - stk_push and stk_pop are never both high.
- **RUN, en=0:** hold pc; no push/pop.
- **RUN, en=1, by op:**
  - SEQ: pc<=pc+1.
  - JMP: pc<=target.
  - BR: pc<=cond ? target : pc+1.
  - CALL, depth<STACK_ENTRIES: stk_push=1, stk_d=pc+1 the same cycle; pc<=target; depth+1.
  - CALL, depth==STACK_ENTRIES: no push; ->ERROR, err_code 01; pc holds.
  - RET, depth>0: stk_pop=1; depth-1; ->RET_WAIT; pc holds.
  - RET, depth==0: no pop; ->ERROR, err_code 10.
  - HALT: ->HALT; pc holds.
  - 6/7: ->ERROR, err_code 11.
- **RET_WAIT:** en and op ignored; pc<=stk_q; ->RUN. A return costs 2 cycles with exactly one pc_valid-low cycle.
- **HALT/ERROR:**
  - en ignored; pc, depth and err_code hold.
  - restart=1 -> pc<=RESET_PC, depth<=0, err_code<=00, stk_clr=1 for that cycle, ->RUN.
  - restart in RUN/RET_WAIT is ignored.
- **Arithmetic:** pc+1 wraps modulo 2^ADDR_W (0xFFFF+1 = 0x0000).
- **depth:** changes only on accepted CALL/RET; saturation is impossible by construction.
- **Reset during RET_WAIT:** the pending pop result is discarded. The stack is reset by the same reset net.

Decomposition:
- Package seq_pkg holds:
  - op enum (OP_SEQ..OP_HALT);
  - state enum (S_RUN, S_RET_WAIT, S_HALT, S_ERROR);
  - err_code constants (ERR_NONE, ERR_OVF, ERR_UNF, ERR_ILL).
- Single module; no sub-module. Next-PC mux and FSM live in one file.

Test Plan:
1. Reset, en=1, op=SEQ for 3 cycles -> pc 0x0000,0x0001,0x0002,0x0003; stk_push=stk_pop=0 throughout.
2. At pc=0x0010, CALL target 0x0100 -> same cycle stk_push=1, stk_d=0x0011; next pc=0x0100, depth=1. At 0x0105, RET -> stk_pop=1; next cycle bench drives stk_q=0x0011, pc_valid=0; then pc=0x0011, pc_valid=1, depth=0.
3. Four nested CALLs (depth=4), fifth CALL -> stk_push stays 0, err=1, err_code=01, pc unchanged. restart=1 -> stk_clr pulses 1 cycle, pc=0x0000, depth=0, err=0, pc_valid=1.
4. RET at depth 0 -> stk_pop never asserts, err_code=10. op=7 in RUN (after restart) -> err_code=11.
5. BR at 0x0020: cond=0 -> 0x0021; at 0x0021, cond=1 target 0x0040 -> 0x0040. SEQ at pc=0xFFFF -> 0x0000. en=0 -> pc holds.
6. HALT -> halted=1, pc_valid=0, subsequent en/op ignored. Separately: async reset asserted mid-RET_WAIT (between clock edges) -> pc=RESET_PC and state RUN before the next edge, depth=0.
